// File: rtl/logic16_arbiter_pkg.sv
// ============================================================================
// Module   : logic16_arbiter_pkg
// Purpose  : Opcode constants and FSM state type for the shared logic unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package logic16_arbiter_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/logic16_unit.sv
// ============================================================================
// Module   : logic16_unit
// Purpose  : Combinational bitwise AND/OR/XOR/NAND unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic16_unit
    import logic16_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            default: o_y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic16_arbiter.sv
// ============================================================================
// Module   : logic16_arbiter
// Purpose  : Round-robin sharing of one bitwise logic unit among N_REQ clients.
// Revision : 1.0
// ============================================================================
`default_nettype none

module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a_in,
    input  logic [WIDTH*N_REQ-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_id
);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [1:0]       r_id;

    logic [WIDTH-1:0] w_a  [N_REQ];
    logic [WIDTH-1:0] w_b  [N_REQ];
    logic [1:0]       w_op [N_REQ];
    logic             w_found;
    logic [1:0]       w_win;
    logic [2:0]       w_sum;
    logic [1:0]       w_idx;
    logic [1:0]       w_ptr_next;
    logic [WIDTH-1:0] w_y;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_a[i]  = a_in[WIDTH*i +: WIDTH];
        assign w_b[i]  = b_in[WIDTH*i +: WIDTH];
        assign w_op[i] = op[2*i +: 2];
    end

    // Scan ptr, ptr+1, ... (mod N_REQ) and keep the first active request.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + 3'(k);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            w_idx = w_sum[1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (r_state == IDLE) && w_found && (w_win == 2'(i));
        end
    end

    assign w_ptr_next = (w_win == 2'(N_REQ - 1)) ? 2'd0 : w_win + 2'd1;
    assign busy       = (r_state == EXEC) || (r_state == RESP);

    logic16_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_y)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_id      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a     <= w_a[w_win];
                        r_b     <= w_b[w_win];
                        r_op    <= w_op[w_win];
                        r_id    <= w_win;
                        r_ptr   <= w_ptr_next;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    out_data  <= w_y;
                    out_id    <= r_id;
                    out_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic16_arbiter.sv
// ============================================================================
// Module   : tb_logic16_arbiter
// Purpose  : Directed self-checking bench for logic16_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_logic16_arbiter;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req     = '0;
    logic [7:0]  op      = '0;
    logic [63:0] a_in    = '0;
    logic [63:0] b_in    = '0;
    logic [3:0]  gnt;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_id;

    int n_tests = 0;
    int n_fail  = 0;

    logic16_arbiter #(
        .N_REQ (4),
        .WIDTH (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clock = ~clock;

    task automatic test_reset;
        #3 reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt cycle %0d: got %b want 0000", c, gnt); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy cycle %0d: got %b want 0", c, busy); end
        end
    endtask

    task automatic test_single_and;
        @(negedge clock);
        req = 4'b0001; op[1:0] = 2'b00; a_in[15:0] = 16'h3CC3; b_in[15:0] = 16'h0FF0;
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T: got %b want 0", busy); end
        @(negedge clock);
        req = 4'b0000;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T1: got %b want 1", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T1: got %b want 0", out_valid); end
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_T2: got %b want 1", out_valid); end
        n_tests++; if (out_data !== 16'h0CC0) begin n_fail++; $display("FAIL single_data: got %h want 0cc0", out_data); end
        n_tests++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", out_id); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T2: got %b want 1", busy); end
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_T3: got %b want 0", out_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T3: got %b want 0", busy); end
        n_tests++; if (out_data !== 16'h0CC0) begin n_fail++; $display("FAIL single_data_hold: got %h want 0cc0", out_data); end
    endtask

    task automatic test_opcodes;
        logic [1:0]  t_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [15:0] t_a   [4] = '{16'h1234, 16'h1234, 16'h1234, 16'hFFFF};
        logic [15:0] t_b   [4] = '{16'h9876, 16'h9876, 16'h9876, 16'hFFFF};
        logic [15:0] t_exp [4] = '{16'h1034, 16'h9A76, 16'h8A42, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            req = 4'b0100; op[5:4] = t_op[k]; a_in[47:32] = t_a[k]; b_in[47:32] = t_b[k];
            #1;
            n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL opc%0d_gnt: got %b want 0100", k, gnt); end
            @(negedge clock);
            req = 4'b0000;
            @(negedge clock);
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL opc%0d_valid: got %b want 1", k, out_valid); end
            n_tests++; if (out_data !== t_exp[k]) begin n_fail++; $display("FAIL opc%0d_data: got %h want %h", k, out_data, t_exp[k]); end
            n_tests++; if (out_id !== 2'd2) begin n_fail++; $display("FAIL opc%0d_id: got %0d want 2", k, out_id); end
            @(negedge clock);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0]  e_gnt;
        logic [15:0] e_data;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        op   = 8'h00;
        a_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        b_in = {4{16'hFFFF}};
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e_gnt  = 4'(1 << (k % 4));
            e_data = 16'h1111 * 16'(k % 4 + 1);
            #1;
            n_tests++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rr%0d_gnt: got %b want %b", k, gnt, e_gnt); end
            @(negedge clock);
            n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr%0d_gnt_exec: got %b want 0000", k, gnt); end
            @(negedge clock);
            n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr%0d_gnt_resp: got %b want 0000", k, gnt); end
            n_tests++; if (out_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr%0d_id: got %0d want %0d", k, out_id, k % 4); end
            n_tests++; if (out_data !== e_data) begin n_fail++; $display("FAIL rr%0d_data: got %h want %h", k, out_data, e_data); end
            @(negedge clock);
        end
        req = 4'b0101;
        #1;
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rr_drop_gnt_a: got %b want 0100", gnt); end
        repeat (3) @(negedge clock);
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_drop_gnt_b: got %b want 0001", gnt); end
        @(negedge clock);
        req = 4'b0000;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_isolation;
        @(negedge clock);
        req = 4'b0001; op[1:0] = 2'b00; a_in[15:0] = 16'h3CC3; b_in[15:0] = 16'h0FF0;
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL iso_gnt0: got %b want 0001", gnt); end
        @(negedge clock);
        a_in[15:0] = 16'hFFFF;
        req = 4'b0010; op[3:2] = 2'b01; a_in[31:16] = 16'h00F0; b_in[31:16] = 16'h0F00;
        #1;
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL iso_gnt_exec: got %b want 0000", gnt); end
        @(negedge clock);
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL iso_gnt_resp: got %b want 0000", gnt); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL iso_valid0: got %b want 1", out_valid); end
        n_tests++; if (out_data !== 16'h0CC0) begin n_fail++; $display("FAIL iso_data0: got %h want 0cc0", out_data); end
        @(negedge clock);
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL iso_gnt1: got %b want 0010", gnt); end
        @(negedge clock);
        req = 4'b0000;
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL iso_valid1: got %b want 1", out_valid); end
        n_tests++; if (out_data !== 16'h0FF0) begin n_fail++; $display("FAIL iso_data1: got %h want 0ff0", out_data); end
        n_tests++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL iso_id1: got %0d want 1", out_id); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        req = 4'b0001; op[1:0] = 2'b00; a_in[15:0] = 16'h3CC3; b_in[15:0] = 16'h0FF0;
        #1;
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt0: got %b want 0001", gnt); end
        @(negedge clock);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_exec: got %b want 1", busy); end
        reset_n = 1'b0;
        req = 4'b1010;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_rst: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_data_rst: got %h want 0000", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt_rst: got %b want 0010", gnt); end
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse: got %b want 0", out_valid); end
        reset_n = 1'b1;
        #1;
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_gnt_rel: got %b want 0010", gnt); end
        @(negedge clock);
        req = 4'b0000;
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_after: got %b want 1", out_valid); end
        n_tests++; if (out_id !== 2'd1) begin n_fail++; $display("FAIL mid_id_after: got %0d want 1", out_id); end
        n_tests++; if (out_data !== 16'h0FF0) begin n_fail++; $display("FAIL mid_data_after: got %h want 0ff0", out_data); end
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_and();
        test_opcodes();
        test_round_robin();
        test_isolation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
